// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   op_e    - 4-bit operation codes (12..15 are reserved; OP_RSV marks the first)
//   state_e - control states of alu_pipe
//   flags_t - result flags {v, c, n, z}
package alu_pkg;

    typedef enum logic [3:0] {
        OP_TFR = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_DEC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_SAR = 4'd10,
        OP_MUL = 4'd11,
        OP_RSV = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    // Shifts take one cycle per bit position.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake bundle for alu_pipe.
//   Request : in_valid/in_ready, op, cin, use_cf, a, b
//   Response: out_valid/out_ready, g, v, c, n, z, err
//   Status  : cf (stored carry flag)
// master = issuer/consumer side, slave = the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             cin;
    logic             use_cf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] g;
    logic             v;
    logic             c;
    logic             n;
    logic             z;
    logic             err;
    logic             cf;

    modport master (
        output in_valid, op, cin, use_cf, a, b, out_ready,
        input  in_ready, out_valid, g, v, c, n, z, err, cf
    );

    modport slave (
        input  in_valid, op, cin, use_cf, a, b, out_ready,
        output in_ready, out_valid, g, v, c, n, z, err, cf
    );
endinterface

// File: rtl/alu_comb.sv
// alu_comb: combinational single-cycle ALU ops (TFR/ADD/SUB/DEC/AND/OR/XOR/NOT)
// with flag generation; reserved codes raise err with g=0.
//   op, ci, a, b : operation, effective carry-in, operands
//   g, flags, err: result, {v,c,n,z}, reserved-op indication
// Shift and multiply codes produce zeros here; alu_pipe iterates those.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output flags_t           flags,
    output logic             err
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             arith;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        addend = '0;
        arith  = 1'b0;
        g      = '0;
        err    = 1'b0;
        flags  = '0;

        case (op)
            OP_TFR: arith = 1'b1;
            OP_ADD: begin addend = b;  arith = 1'b1; end
            OP_SUB: begin addend = ~b; arith = 1'b1; end
            OP_DEC: begin addend = '1; arith = 1'b1; end
            OP_AND: g = a & b;
            OP_OR:  g = a | b;
            OP_XOR: g = a ^ b;
            OP_NOT: g = ~a;
            OP_SHL, OP_SHR, OP_SAR, OP_MUL: ;
            default: err = 1'b1;
        endcase

        sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, ci};

        if (arith) begin
            g       = sum[WIDTH-1:0];
            flags.c = sum[WIDTH];
            // Overflow: both addends share a sign the result does not.
            flags.v = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end

        flags.n = g[WIDTH-1];
        flags.z = (g == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags, bit-serial shifts,
// shift-add multiply and a stored carry flag for chained arithmetic.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave): in_valid/in_ready + op/cin/use_cf/a/b request,
//                out_valid/out_ready + g/v/c/n/z/err response, cf status
// One op is accepted per in_valid&in_ready; the result is held until
// out_valid&out_ready. In DONE a new op may be accepted on the same edge
// as the handoff, and use_cf then sees the carry being handed off.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);

    localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] CNT_MUL = (CNT_W+1)'(WIDTH);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;   // shift operand, or multiplicand
    logic [WIDTH-1:0] mplr_q, mplr_d;   // multiplier, becomes product low half
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] g_q, g_d;
    flags_t           flags_q, flags_d;
    logic             err_q, err_d;
    logic             cf_q, cf_d;

    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;
    logic             ci_eff;
    logic [CNT_W-1:0] amt;
    logic             in_shift;
    logic             in_mul;
    logic             accept_busy;

    logic [WIDTH-1:0] comb_g;
    flags_t           comb_flags;
    logic             comb_err;

    logic [WIDTH-1:0] shift_val;
    logic             shift_out;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] fin_g;
    logic             fin_c;

    // ---------------- handshake / decode ----------------
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid & bus.out_ready;
    assign amt      = bus.b[CNT_W-1:0];
    assign in_shift = is_shift(bus.op);
    assign in_mul   = (bus.op == OP_MUL);
    // Zero-length shifts complete like single-cycle ops.
    assign accept_busy = in_mul || (in_shift && (amt != '0));
    // Forward the carry being handed off this cycle.
    assign ci_eff = bus.use_cf ? (out_fire ? flags_q.c : cf_q) : bus.cin;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op    (bus.op),
        .ci    (ci_eff),
        .a     (bus.a),
        .b     (bus.b),
        .g     (comb_g),
        .flags (comb_flags),
        .err   (comb_err)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_fire) state_d = accept_busy ? BUSY : DONE;
            BUSY: if (cnt_q == CNT_ONE) state_d = DONE;
            DONE: begin
                if (in_fire)            state_d = accept_busy ? BUSY : DONE;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                in_ready  = bus.out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.g         = g_q;
    assign bus.v         = flags_q.v;
    assign bus.c         = flags_q.c;
    assign bus.n         = flags_q.n;
    assign bus.z         = flags_q.z;
    assign bus.err       = err_q;
    assign bus.cf        = cf_q;

    // ---------------- iteration step ----------------
    always_comb begin
        shift_val = work_q;
        shift_out = 1'b0;
        case (op_q)
            OP_SHL: begin
                shift_val = {work_q[WIDTH-2:0], 1'b0};
                shift_out = work_q[WIDTH-1];
            end
            OP_SHR: begin
                shift_val = {1'b0, work_q[WIDTH-1:1]};
                shift_out = work_q[0];
            end
            OP_SAR: begin
                shift_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                shift_out = work_q[0];
            end
            default: ;
        endcase

        // Shift-add: add multiplicand to the high half when the multiplier
        // LSB is set, then shift {carry, high, low} right by one.
        mul_sum = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, work_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], mplr_q[WIDTH-1:1]};

        if (op_q == OP_MUL) begin
            fin_g = mul_lo;
            fin_c = |mul_hi;
        end else begin
            fin_g = shift_val;
            fin_c = shift_out;
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        op_d    = op_q;
        work_d  = work_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        flags_d = flags_q;
        err_d   = err_q;
        cf_d    = cf_q;

        if (out_fire) cf_d = flags_q.c;

        if (in_fire) begin
            op_d   = bus.op;
            work_d = bus.a;
            mplr_d = bus.b;
            acc_d  = '0;
            cnt_d  = in_mul ? CNT_MUL : {1'b0, amt};
            if (!accept_busy) begin
                if (in_shift) begin
                    g_d       = bus.a;
                    flags_d.v = 1'b0;
                    flags_d.c = 1'b0;
                    flags_d.n = bus.a[WIDTH-1];
                    flags_d.z = (bus.a == '0);
                    err_d     = 1'b0;
                end else begin
                    g_d     = comb_g;
                    flags_d = comb_flags;
                    err_d   = comb_err;
                end
            end
        end else if (state_q == BUSY) begin
            work_d = (op_q == OP_MUL) ? work_q : shift_val;
            if (op_q == OP_MUL) begin
                acc_d  = mul_hi;
                mplr_d = mul_lo;
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                g_d       = fin_g;
                flags_d.v = 1'b0;
                flags_d.c = fin_c;
                flags_d.n = fin_g[WIDTH-1];
                flags_d.z = (fin_g == '0);
                err_d     = 1'b0;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: there are no memory arrays here; every register is reset so
        // the outputs read 0 and a pending result is dropped on reset.
        if (!rst_n) begin
            op_q    <= '0;
            work_q  <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            g_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            op_q    <= op_d;
            work_q  <= work_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            cf_q    <= cf_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=8).
// Expected results come from an independent reference model, are queued
// when an op is accepted and popped when the DUT presents a result.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] g;
        logic       v;
        logic       c;
        logic       n;
        logic       z;
        logic       err;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    logic cf_model = 1'b0;
    logic pending_c = 1'b0;
    res_t obs;
    logic [3:0] rop;
    logic [7:0] ra, rb;
    logic       rcin, ruse;

    // Reference model, written from the operation definitions.
    function automatic res_t model(input logic [3:0] op, input logic ci,
                                   input logic [7:0] a, input logic [7:0] b);
        res_t       r;
        logic [7:0] second;
        logic [7:0] w;
        logic [15:0] p;
        int         su;
        int         ss;
        r = '0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                second = (op == 4'd0) ? 8'h00 : (op == 4'd1) ? b : (op == 4'd2) ? ~b : 8'hFF;
                su  = int'(a) + int'(second) + int'(ci);
                ss  = int'($signed(a)) + int'($signed(second)) + int'(ci);
                r.g = su[7:0];
                r.c = (su > 255);
                r.v = (ss > 127) || (ss < -128);
            end
            4'd4: r.g = a & b;
            4'd5: r.g = a | b;
            4'd6: r.g = a ^ b;
            4'd7: r.g = ~a;
            4'd8, 4'd9, 4'd10: begin
                w = a;
                for (int i = 0; i < int'(b[2:0]); i++) begin
                    if (op == 4'd8) begin
                        r.c = w[7];
                        w   = {w[6:0], 1'b0};
                    end else if (op == 4'd9) begin
                        r.c = w[0];
                        w   = {1'b0, w[7:1]};
                    end else begin
                        r.c = w[0];
                        w   = {w[7], w[7:1]};
                    end
                end
                r.g = w;
            end
            4'd11: begin
                p   = 16'(a) * 16'(b);
                r.g = p[7:0];
                r.c = (p[15:8] != 8'h00);
            end
            default: r.err = 1'b1;
        endcase
        r.n = r.g[7];
        r.z = (r.g == 8'h00);
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one op, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input logic [3:0] op, input logic cin, input logic use_cf,
                        input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.op = op; bus.cin = cin; bus.use_cf = use_cf; bus.a = a; bus.b = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("send_ready", 16'(bus.in_ready), 16'(1'b1));
        sb_q.push_back(model(op, use_cf ? cf_model : cin, a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and result against the queue.
    task automatic recv(input string tag, input int exp_wait);
        int   n = 0;
        res_t e;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, 16'(bus.out_valid), 16'(1'b1));
        check({tag, "_lat"}, 16'(n), 16'(exp_wait));
        e = sb_q.pop_front();
        obs.g = bus.g; obs.v = bus.v; obs.c = bus.c; obs.n = bus.n; obs.z = bus.z; obs.err = bus.err;
        check({tag, "_g"}, 16'(obs.g), 16'(e.g));
        check({tag, "_flags"}, 16'({obs.v, obs.c, obs.n, obs.z, obs.err}),
              16'({e.v, e.c, e.n, e.z, e.err}));
        pending_c = e.c;
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        cf_model = pending_c;
        check({tag, "_cf"}, 16'(bus.cf), 16'(cf_model));
        check({tag, "_idle"}, 16'(bus.out_valid), 16'(1'b0));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.cin = 1'b0; bus.use_cf = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 16'(bus.in_ready), 16'(1'b1));
        check("rst_out_valid", 16'(bus.out_valid), 16'(1'b0));
        check("rst_g", 16'(bus.g), 16'h0);
        check("rst_cf", 16'(bus.cf), 16'(1'b0));
        check("rst_flags", 16'({bus.v, bus.c, bus.n, bus.z, bus.err}), 16'h0);

        // Signed overflow
        send(OP_ADD, 1'b0, 1'b0, 8'h7F, 8'h01);
        recv("add_ovf", 0);
        check("add_ovf_const", 16'({obs.g, obs.v, obs.c, obs.n, obs.z}), 16'({8'h80, 4'b1010}));
        handoff("add_ovf");

        // Carry chain
        send(OP_ADD, 1'b0, 1'b0, 8'hFF, 8'h01);
        recv("add_carry", 0);
        check("add_carry_const", 16'({obs.g, obs.c, obs.z}), 16'({8'h00, 2'b11}));
        handoff("add_carry");
        send(OP_ADD, 1'b0, 1'b1, 8'h00, 8'h00);
        recv("add_chain", 0);
        check("add_chain_const", 16'(obs.g), 16'h01);
        handoff("add_chain");

        // Shifts
        send(OP_SHL, 1'b0, 1'b0, 8'h81, 8'h03);
        recv("shl3", 3);
        check("shl3_const", 16'({obs.g, obs.c}), 16'({8'h08, 1'b0}));
        handoff("shl3");
        send(OP_SAR, 1'b0, 1'b0, 8'h80, 8'h07);
        recv("sar7", 7);
        check("sar7_const", 16'({obs.g, obs.c}), 16'({8'hFF, 1'b0}));
        handoff("sar7");
        send(OP_SHR, 1'b0, 1'b0, 8'hB5, 8'h00);
        recv("shr0", 0);
        handoff("shr0");
        send(OP_SHR, 1'b0, 1'b0, 8'h03, 8'h02);
        recv("shr2", 2);
        handoff("shr2");

        // Multiply
        send(OP_MUL, 1'b0, 1'b0, 8'h10, 8'h11);
        recv("mul_a", WIDTH);
        check("mul_a_const", 16'({obs.g, obs.c}), 16'({8'h10, 1'b1}));
        handoff("mul_a");
        send(OP_MUL, 1'b0, 1'b0, 8'h0F, 8'h0F);
        recv("mul_b", WIDTH);
        handoff("mul_b");

        // Random single-cycle ops, including chained carries
        for (int i = 0; i < 12; i++) begin
            rop  = 4'($urandom_range(0, 7));
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rcin = 1'($urandom_range(0, 1));
            ruse = 1'($urandom_range(0, 1));
            send(rop, rcin, ruse, ra, rb);
            recv("rand", 0);
            handoff("rand");
        end

        // Reserved codes
        send(4'hE, 1'b1, 1'b0, 8'h55, 8'hAA);
        recv("rsv_e", 0);
        check("rsv_e_const", 16'({obs.g, obs.z, obs.err}), 16'({8'h00, 2'b11}));
        handoff("rsv_e");
        send(4'hF, 1'b0, 1'b0, 8'hFF, 8'hFF);
        recv("rsv_f", 0);
        handoff("rsv_f");

        // Backpressure, then accept on the handoff edge with forwarded carry
        send(OP_SUB, 1'b1, 1'b0, 8'h05, 8'h03);
        recv("bp", 0);
        bus.op = OP_ADD; bus.cin = 1'b0; bus.use_cf = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 16'(bus.in_ready), 16'(1'b0));
            check("bp_out_valid", 16'(bus.out_valid), 16'(1'b1));
            check("bp_g", 16'(bus.g), 16'(obs.g));
            check("bp_flags", 16'({bus.v, bus.c, bus.n, bus.z}), 16'({obs.v, obs.c, obs.n, obs.z}));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 16'(bus.in_ready), 16'(1'b1));
        cf_model = pending_c;
        sb_q.push_back(model(OP_ADD, cf_model, 8'h10, 8'h20));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_cf", 16'(bus.cf), 16'(cf_model));
        recv("b2b", 0);
        check("b2b_const", 16'(obs.g), 16'h31);
        handoff("b2b");

        // Reset while a multiply is iterating
        send(OP_MUL, 1'b0, 1'b0, 8'hFF, 8'hFF);
        recv("mul_c", WIDTH);
        handoff("mul_c");
        send(OP_MUL, 1'b0, 1'b0, 8'h12, 8'h34);
        repeat (3) begin @(posedge clk); #1; end
        check("busy_in_ready", 16'(bus.in_ready), 16'(1'b0));
        check("busy_out_valid", 16'(bus.out_valid), 16'(1'b0));
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 16'(bus.out_valid), 16'(1'b0));
        check("arst_in_ready", 16'(bus.in_ready), 16'(1'b1));
        check("arst_cf", 16'(bus.cf), 16'(1'b0));
        check("arst_g", 16'(bus.g), 16'h0);
        sb_q.delete();
        cf_model = 1'b0;
        #1 rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check("arst_dropped", 16'(bus.out_valid), 16'(1'b0));

        // Operation after reset, carry taken from the cleared flag
        send(OP_XOR, 1'b0, 1'b0, 8'h5A, 8'hFF);
        recv("post_xor", 0);
        handoff("post_xor");
        send(OP_TFR, 1'b1, 1'b1, 8'h7F, 8'h00);
        recv("post_tfr", 0);
        handoff("post_tfr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
